// File: rtl/piso_tx_ctrl.sv
// Round-robin transmit controller feeding a 16-bit parallel-in/serial-out shifter.
// Grants one of two requesters, strobes the load, then frames the 16 serial bits.
module piso_tx_ctrl #(
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  ack,
    output logic        piso_load,
    output logic [15:0] piso_d,
    output logic        frame_valid,
    output logic        sof,
    output logic        eof,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  shift_cnt_q, shift_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic [15:0] data_q, data_d;
    logic        fv_q, sof_q, eof_q;
    logic        gnt;

    // Both requesting: serve whoever was not served last; otherwise the lone requester.
    assign gnt = (req == 2'b11) ? ~last_q : req[1];

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        last_d      = last_q;
        owner_d     = owner_q;
        data_d      = data_q;
        ack         = 2'b00;
        case (state_q)
            IDLE: begin
                if (en && (req != 2'b00) && !rst) begin
                    ack     = gnt ? 2'b10 : 2'b01;
                    owner_d = gnt;
                    last_d  = gnt;
                    data_d  = gnt ? data1 : data0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_cnt_d = 4'd0;
                state_d     = SHIFT;
            end
            SHIFT: begin
                shift_cnt_d = shift_cnt_q + 4'd1;
                if (shift_cnt_q == 4'd15) begin
                    gap_cnt_d = 4'd0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame flags are registered one cycle behind SHIFT to line up with the
    // shifter's registered serial output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_cnt_q <= 4'd0;
            gap_cnt_q   <= 4'd0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            data_q      <= 16'h0000;
            fv_q        <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            data_q      <= data_d;
            fv_q        <= (state_q == SHIFT);
            sof_q       <= (state_q == SHIFT) && (shift_cnt_q == 4'd0);
            eof_q       <= (state_q == SHIFT) && (shift_cnt_q == 4'd15);
        end
    end

    assign piso_load   = (state_q == LOAD);
    assign piso_d      = data_q;
    assign frame_valid = fv_q;
    assign sof         = sof_q;
    assign eof         = eof_q;
    assign owner       = owner_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl: one instance with GAP_CYCLES=1 plus a
// PISO model, and one with GAP_CYCLES=4 sharing the same stimulus.
module tb_piso_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [1:0]  req;
    logic [15:0] data0, data1;
    logic [1:0]  ack, ack4;
    logic        piso_load, frame_valid, sof, eof, owner, busy;
    logic        piso_load4, frame_valid4, sof4, eof4, owner4, busy4;
    logic [15:0] piso_d, piso_d4;
    logic [15:0] sreg = 16'h0;
    logic        sout = 1'b0;
    int          nvec = 0, nfail = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_tx_ctrl #(.GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .data0(data0), .data1(data1),
        .ack(ack), .piso_load(piso_load), .piso_d(piso_d), .frame_valid(frame_valid),
        .sof(sof), .eof(eof), .owner(owner), .busy(busy));

    piso_tx_ctrl #(.GAP_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .req(req), .data0(data0), .data1(data1),
        .ack(ack4), .piso_load(piso_load4), .piso_d(piso_d4), .frame_valid(frame_valid4),
        .sof(sof4), .eof(eof4), .owner(owner4), .busy(busy4));

    // Shifter with registered serial output
    always @(posedge clk) begin
        if (piso_load) sreg <= piso_d;
        else           sreg <= {sreg[14:0], 1'b0};
        sout <= sreg[15];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input int bound);
        int n;
        n = 0;
        while (ack == 2'b00 && n < bound) begin
            step();
            #1;
            n++;
        end
        if (ack == 2'b00) chk("ack_timeout", 32'(ack), 32'h1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            step();
            #1;
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'h0);
    endtask

    initial begin
        logic [15:0] w;
        int ld_prev, ld_now;
        ld_prev = 0;
        ld_now  = 0;
        w = 16'hA5C3;
        rst = 1'b1; en = 1'b0; req = 2'b00; data0 = 16'h0; data1 = 16'h0;
        step(); step(); step();
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_load", 32'(piso_load), 32'h0);
        chk("rst_d", 32'(piso_d), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_sof_eof", 32'({sof, eof}), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Single word; no grant while rst is still high
        en = 1'b1; req = 2'b01; data0 = w;
        #1;
        chk("ack_in_rst", 32'(ack), 32'h0);
        step();
        rst = 1'b0;
        #1;
        chk("t1_ack", 32'(ack), 32'h1);
        step();
        req = 2'b00;
        #1;
        chk("t1_load", 32'(piso_load), 32'h1);
        chk("t1_ack_off", 32'(ack), 32'h0);
        chk("t1_d", 32'(piso_d), 32'hA5C3);
        chk("t1_busy", 32'(busy), 32'h1);
        for (int k = 1; k <= 17; k++) begin
            step();
            #1;
            chk("t1_fv", 32'(frame_valid), 32'(k >= 2));
            if (k >= 2) chk("t1_sout", 32'(sout), 32'(w[17-k]));
            chk("t1_sof", 32'(sof), 32'(k == 2));
            chk("t1_eof", 32'(eof), 32'(k == 17));
            chk("t1_noload", 32'(piso_load), 32'h0);
        end
        chk("t1_gap_busy", 32'(busy), 32'h1);
        step();
        #1;
        chk("t1_idle", 32'(busy), 32'h0);

        // Contention with round-robin from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0; req = 2'b11; data0 = 16'h00FF; data1 = 16'hFF00;
        #1;
        for (int g = 0; g < 4; g++) begin
            wait_ack(40);
            chk("rr_ack", 32'(ack), (g % 2 == 0) ? 32'h1 : 32'h2);
            step();
            #1;
            ld_now = cyc;
            chk("rr_load", 32'(piso_load), 32'h1);
            chk("rr_d", 32'(piso_d), (g % 2 == 0) ? 32'h00FF : 32'hFF00);
            chk("rr_owner", 32'(owner), 32'(g % 2));
            if (g > 0) chk("rr_spacing", 32'(ld_now - ld_prev), 32'd19);
            ld_prev = ld_now;
        end
        req = 2'b00;
        wait_idle(40);

        // Enable gating
        en = 1'b0; req = 2'b10; data1 = 16'h1234;
        for (int k = 0; k < 10; k++) begin
            step();
            #1;
            chk("en0_ack", 32'(ack), 32'h0);
            chk("en0_busy", 32'(busy), 32'h0);
        end
        en = 1'b1;
        #1;
        chk("en1_ack", 32'(ack), 32'h2);
        step();
        #1;
        chk("en1_owner", 32'(owner), 32'h1);
        // Drop enable at T5; the frame must still complete
        for (int k = 0; k < 5; k++) step();
        en = 1'b0;
        for (int k = 0; k < 12; k++) step();
        #1;
        chk("endrop_eof", 32'({frame_valid, eof}), 32'h3);
        for (int k = 0; k < 10; k++) begin
            step();
            #1;
            chk("endrop_noack", 32'(ack), 32'h0);
        end
        chk("endrop_idle", 32'(busy), 32'h0);
        en = 1'b1;
        #1;
        chk("endrop_regrant", 32'(ack), 32'h2);
        step();
        req = 2'b00;
        #1;
        wait_idle(40);

        // Reset mid-frame while serving requester 0
        req = 2'b01; data0 = 16'hBEEF;
        #1;
        chk("rm_ack", 32'(ack), 32'h1);
        for (int k = 0; k <= 8; k++) step();
        rst = 1'b1;
        step();
        #1;
        chk("rm_busy", 32'(busy), 32'h0);
        chk("rm_fv", 32'(frame_valid), 32'h0);
        chk("rm_load", 32'(piso_load), 32'h0);
        chk("rm_d", 32'(piso_d), 32'h0);
        chk("rm_ack_in_rst", 32'(ack), 32'h0);
        rst = 1'b0; req = 2'b11;
        #1;
        chk("rm_rr_restart", 32'(ack), 32'h1);

        // GAP_CYCLES=4 instance against the GAP_CYCLES=1 instance
        rst = 1'b1;
        step();
        rst = 1'b0; req = 2'b01; en = 1'b1;
        #1;
        chk("g4_first_ack", 32'(ack4), 32'h1);
        step();
        for (int k = 1; k <= 21; k++) begin
            step();
            #1;
            if (k >= 17 && k <= 20) begin
                chk("g4_gap_busy", 32'(busy4), 32'h1);
                chk("g4_gap_noack", 32'(ack4), 32'h0);
            end
            if (k == 18) chk("g1_next_ack", 32'(ack), 32'h1);
            if (k == 21) chk("g4_next_ack", 32'(ack4), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/piso_tx_ctrl.md
PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

Interface
REQ-001 Parameter GAP_CYCLES, default 1, idle cycles after each frame before the next arbitration; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  arbitration enable; when low, no new word is granted, and a frame already in progress completes.
REQ-005 req  input  2  per-requester level request; bit i means data_i holds a valid word.
REQ-006 data0  input  16  word offered by requester 0.
REQ-007 data1  input  16  word offered by requester 1.
REQ-008 ack  output  2  one-cycle pulse on bit i when requester i's word is captured.
REQ-009 piso_load  output  1  load strobe to the 16-bit PISO shifter.
REQ-010 piso_d  output  16  parallel word to the shifter.
REQ-011 frame_valid  output  1  high while the shifter's serial_out carries a frame bit.
REQ-012 sof  output  1  high with the first (MSB) serial bit of a frame.
REQ-013 eof  output  1  high with the last (LSB) serial bit of a frame.
REQ-014 owner  output  1  index of the requester whose frame is in progress; valid while busy.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SHIFT and GAP, with exactly one state active per cycle.
REQ-017 In IDLE with en=1 and req!=0, the block SHALL grant one requester, pulse that requester's ack bit, latch its data into piso_d, and go to LOAD next cycle.
REQ-018 In IDLE with en=0 or req=0, the block SHALL stay in IDLE with ack=0.
REQ-019 Arbitration SHALL be round-robin: if both bits are set, grant the requester not served last; after reset, requester 0 wins.
REQ-020 If only one request is set, that requester SHALL be granted regardless of the round-robin pointer.
REQ-021 piso_load SHALL be 1 only during the single LOAD cycle (T0); piso_d SHALL hold the latched word from LOAD until the next grant.
REQ-022 SHIFT SHALL last exactly 16 cycles (T1..T16) with piso_load=0, tracked by a 4-bit counter that ends at 15.
REQ-023 frame_valid SHALL be high in cycles T2..T17, matching the shifter's registered serial_out, which shows bit 15 at T2 and bit 0 at T17.
REQ-024 sof SHALL be high only at T2; eof SHALL be high only at T17; both SHALL be qualified by frame_valid.
REQ-025 GAP SHALL start at T17 and last GAP_CYCLES cycles with piso_load=0, then return to IDLE.
REQ-026 The earliest next ack SHALL be at cycle T17+GAP_CYCLES, and the next LOAD one cycle after that.
REQ-027 req, data and en changes outside IDLE SHALL be ignored, and the latched word SHALL NOT change mid-frame.
REQ-028 owner SHALL update only on a grant and hold its value through LOAD, SHIFT and GAP.
REQ-029 ack SHALL never be asserted outside IDLE, and never on both bits at once.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL force IDLE from any state, including mid-SHIFT, abandoning the frame.
REQ-031 Reset values SHALL be: ack=0, piso_load=0, piso_d=0, frame_valid=0, sof=0, eof=0, owner=0, busy=0, shift counter=0, gap counter=0, round-robin pointer set so requester 0 wins next.
REQ-032 The first grant SHALL occur no earlier than the first edge at which rst=0.

Verification
REQ-033 Single word: req=01, data0=16'hA5C3 -> ack=01 for one cycle, piso_load one cycle later; with a PISO model attached, serial_out carries 1010010111000011 MSB-first under frame_valid, sof at first bit, eof at 16th bit.
REQ-034 Contention: req=11 held, data0=16'h00FF, data1=16'hFF00 -> grants alternate 0,1,0,1; owner follows; consecutive LOAD pulses are 18+GAP_CYCLES cycles apart.
REQ-035 Enable gating: en=0 with req=10 for 10 cycles -> ack=0 and busy=0 throughout; en=1 -> ack=10 on the next cycle.
REQ-036 Enable drop mid-frame: en=0 at T5 -> the frame completes and eof fires at T17; no grant follows until en=1.
REQ-037 Reset mid-frame: rst=1 at T8 -> next cycle busy=0, frame_valid=0, piso_load=0; after release, req=11 -> requester 0 granted first.
REQ-038 GAP_CYCLES=4 with req=01 held -> exactly 4 GAP cycles, and the next ack occurs at T21.
